// File: rtl/mem_pkg.sv
// Shared definitions for the memory-access stage: control-word bit positions,
// FSM state encoding and the timeout counter width.
package mem_pkg;

  localparam int CW_MEMRD = 0;
  localparam int CW_MEMWR = 1;
  localparam int CW_REGWR = 2;
  localparam int CW_WBSEL = 3;

  localparam int TMO_W = 8;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } mem_state_e;

  // A control word requests a memory access if either access bit is set.
  function automatic logic cw_memop(input logic [7:0] cw);
    return cw[CW_MEMRD] | cw[CW_MEMWR];
  endfunction

endpackage

// File: rtl/mem_stage_reg_m2w.sv
// Memory-to-writeback pipeline register. Flush and bubble both load all-zero
// fields, flush taking priority; otherwise the incoming fields are captured.
module reg_m2w (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        load_bubble,
  input  logic [15:0] pc_d,
  input  logic [15:0] instr_d,
  input  logic [7:0]  cw_d,
  input  logic [15:0] alu_d,
  input  logic [15:0] ld_d,
  input  logic [2:0]  dest_d,
  output logic [15:0] pc_q,
  output logic [15:0] instr_q,
  output logic [7:0]  cw_q,
  output logic [15:0] alu_q,
  output logic [15:0] ld_q,
  output logic [2:0]  dest_q
);

  // Writeback-side register: reset, then flush, then bubble, then load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= '0;
      instr_q <= '0;
      cw_q    <= '0;
      alu_q   <= '0;
      ld_q    <= '0;
      dest_q  <= '0;
    end else if (flush || load_bubble) begin
      pc_q    <= '0;
      instr_q <= '0;
      cw_q    <= '0;
      alu_q   <= '0;
      ld_q    <= '0;
      dest_q  <= '0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      cw_q    <= cw_d;
      alu_q   <= alu_d;
      ld_q    <= ld_d;
      dest_q  <= dest_d;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: issues one request/ack data-memory access per
// memory instruction, stalls upstream while it is outstanding, abandons hung
// accesses after MEM_TIMEOUT cycles and feeds the writeback register.
module mem_stage
  import mem_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic [15:0] pc_mem_16,
  input  logic [15:0] instr_mem_16,
  input  logic [7:0]  cw_mem_8,
  input  logic [15:0] in_mem_16,
  input  logic [15:0] ra_mem_16,
  input  logic [2:0]  dest_mem_3,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [15:0] dmem_addr,
  output logic [15:0] dmem_wdata,
  input  logic [15:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        stall_out,
  output logic [15:0] pc_wb_16,
  output logic [15:0] instr_wb_16,
  output logic [7:0]  cw_wb_8,
  output logic [15:0] alu_wb_16,
  output logic [15:0] ld_wb_16,
  output logic [2:0]  dest_wb_3,
  output logic        err_timeout
);

  mem_state_e       state;
  logic [TMO_W-1:0] tmo_cnt;
  logic             memop;
  logic             is_wr;
  logic             timeout_hit;
  logic             retire;
  logic             load_bubble;
  logic [15:0]      ld_data;

  assign memop = cw_memop(cw_mem_8);
  // A write bit wins when both access bits are set.
  assign is_wr = cw_mem_8[CW_MEMWR];

  assign timeout_hit = (state == ACCESS) && !dmem_ack &&
                       (tmo_cnt == TMO_W'(MEM_TIMEOUT - 1));

  assign stall_out = ((state == IDLE) && memop) ||
                     ((state == ACCESS) && !dmem_ack && !timeout_hit);

  // The instruction leaves this stage either as a plain ALU op or on ack;
  // every other cycle (waiting, timeout) sends a bubble downstream.
  assign retire      = ((state == IDLE) && !memop) || ((state == ACCESS) && dmem_ack);
  assign load_bubble = !retire;
  assign ld_data     = ((state == ACCESS) && dmem_ack && !dmem_we) ? dmem_rdata : 16'h0000;

  // Access FSM with registered memory-port outputs and the hang detector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      tmo_cnt     <= '0;
      err_timeout <= 1'b0;
      dmem_req    <= 1'b0;
      dmem_we     <= 1'b0;
      dmem_addr   <= '0;
      dmem_wdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (memop) begin
            dmem_req   <= 1'b1;
            dmem_we    <= is_wr;
            dmem_addr  <= in_mem_16;
            dmem_wdata <= ra_mem_16;
            tmo_cnt    <= '0;
            state      <= ACCESS;
          end else begin
            dmem_req <= 1'b0;
          end
        end
        ACCESS: begin
          if (dmem_ack) begin
            dmem_req <= 1'b0;
            state    <= IDLE;
          end else if (timeout_hit) begin
            dmem_req    <= 1'b0;
            err_timeout <= 1'b1;
            state       <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Memory-to-writeback boundary.
  reg_m2w u_reg_m2w (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .load_bubble (load_bubble),
    .pc_d        (pc_mem_16),
    .instr_d     (instr_mem_16),
    .cw_d        (cw_mem_8),
    .alu_d       (in_mem_16),
    .ld_d        (ld_data),
    .dest_d      (dest_mem_3),
    .pc_q        (pc_wb_16),
    .instr_q     (instr_wb_16),
    .cw_q        (cw_wb_8),
    .alu_q       (alu_wb_16),
    .ld_q        (ld_wb_16),
    .dest_q      (dest_wb_3)
  );

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus a randomized
// instruction stream, checked against a timeline/memory model of the stage.
module tb_mem_stage;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic [15:0] pc_mem_16 = '0;
  logic [15:0] instr_mem_16 = '0;
  logic [7:0]  cw_mem_8 = '0;
  logic [15:0] in_mem_16 = '0;
  logic [15:0] ra_mem_16 = '0;
  logic [2:0]  dest_mem_3 = '0;
  logic        dmem_req;
  logic        dmem_we;
  logic [15:0] dmem_addr;
  logic [15:0] dmem_wdata;
  logic [15:0] dmem_rdata = '0;
  logic        dmem_ack = 1'b0;
  logic        stall_out;
  logic [15:0] pc_wb_16;
  logic [15:0] instr_wb_16;
  logic [7:0]  cw_wb_8;
  logic [15:0] alu_wb_16;
  logic [15:0] ld_wb_16;
  logic [2:0]  dest_wb_3;
  logic        err_timeout;

  int tests = 0;
  int fails = 0;

  logic [15:0] mem     [256];  // memory seen through the port
  logic [15:0] ref_mem [256];  // model's view of the same memory
  bit          exp_err = 1'b0;

  mem_stage #(.MEM_TIMEOUT(T)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .pc_mem_16    (pc_mem_16),
    .instr_mem_16 (instr_mem_16),
    .cw_mem_8     (cw_mem_8),
    .in_mem_16    (in_mem_16),
    .ra_mem_16    (ra_mem_16),
    .dest_mem_3   (dest_mem_3),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_addr    (dmem_addr),
    .dmem_wdata   (dmem_wdata),
    .dmem_rdata   (dmem_rdata),
    .dmem_ack     (dmem_ack),
    .stall_out    (stall_out),
    .pc_wb_16     (pc_wb_16),
    .instr_wb_16  (instr_wb_16),
    .cw_wb_8      (cw_wb_8),
    .alu_wb_16    (alu_wb_16),
    .ld_wb_16     (ld_wb_16),
    .dest_wb_3    (dest_wb_3),
    .err_timeout  (err_timeout)
  );

  always #5 clk = ~clk;

  // Present one instruction and hold it as long as the model says it stays in
  // MEM. wait_n = ack wait cycles, to = never ack (timeout), fl = flush in the
  // instruction's last cycle.
  task automatic run_instr(input string nm, input logic [15:0] pc, input logic [15:0] instr,
                           input logic [7:0] cw, input logic [15:0] in, input logic [15:0] ra,
                           input logic [2:0] dest, input int wait_n, input bit to, input bit fl);
    bit          memop;
    bit          wr;
    int          ncyc;
    logic [82:0] exp_wb;
    logic [82:0] got_wb;
    logic [15:0] exp_ld;
    memop = cw[0] | cw[1];
    wr    = cw[1];
    if (!memop)  ncyc = 1;
    else if (to) ncyc = 1 + T;
    else         ncyc = 2 + wait_n;
    exp_ld = (memop && !wr) ? ref_mem[in[7:0]] : 16'h0000;
    if (fl || (memop && to)) exp_wb = '0;
    else                     exp_wb = {pc, instr, cw, in, exp_ld, dest};
    if (memop && wr && !to) ref_mem[in[7:0]] = ra;
    if (memop && to) exp_err = 1'b1;

    for (int k = 0; k < ncyc; k++) begin
      pc_mem_16    = pc;
      instr_mem_16 = instr;
      cw_mem_8     = cw;
      in_mem_16    = in;
      ra_mem_16    = ra;
      dest_mem_3   = dest;
      flush        = fl && (k == ncyc - 1);
      if (k == 0)
        dmem_ack = ($urandom_range(0, 1) == 1);   // ack while idle must be ignored
      else
        dmem_ack = memop && !to && (k == ncyc - 1);
      if (dmem_ack && k > 0 && !dmem_we) dmem_rdata = mem[dmem_addr[7:0]];
      else                               dmem_rdata = 16'($urandom);
      if (dmem_ack && k > 0 && dmem_we) mem[dmem_addr[7:0]] = dmem_wdata;
      #4;
      tests++;
      if (stall_out !== (k != ncyc - 1)) begin
        fails++;
        $display("FAIL %s stall cyc%0d: got %b want %b", nm, k, stall_out, (k != ncyc - 1));
      end
      tests++;
      if (dmem_req !== (memop && k >= 1)) begin
        fails++;
        $display("FAIL %s req cyc%0d: got %b want %b", nm, k, dmem_req, (memop && k >= 1));
      end
      if (memop && k >= 1) begin
        tests++;
        if ({dmem_we, dmem_addr, dmem_wdata} !== {wr, in, ra}) begin
          fails++;
          $display("FAIL %s port cyc%0d: got we=%b addr=%h wdata=%h want we=%b addr=%h wdata=%h",
                   nm, k, dmem_we, dmem_addr, dmem_wdata, wr, in, ra);
        end
      end
      @(posedge clk);
      #1;
      got_wb = {pc_wb_16, instr_wb_16, cw_wb_8, alu_wb_16, ld_wb_16, dest_wb_3};
      tests++;
      if (k < ncyc - 1) begin
        if (got_wb !== 83'd0) begin
          fails++;
          $display("FAIL %s bubble cyc%0d: got %h want 0", nm, k, got_wb);
        end
      end else begin
        if (got_wb !== exp_wb) begin
          fails++;
          $display("FAIL %s wb: got %h want %h", nm, got_wb, exp_wb);
        end
      end
    end
    flush    = 1'b0;
    dmem_ack = 1'b0;
    tests++;
    if (err_timeout !== exp_err) begin
      fails++;
      $display("FAIL %s err_timeout: got %b want %b", nm, err_timeout, exp_err);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    tests++;
    if ({dmem_req, dmem_we, dmem_addr, dmem_wdata, err_timeout} !== 35'd0) begin
      fails++;
      $display("FAIL reset port: got req=%b we=%b addr=%h wdata=%h err=%b want all 0",
               dmem_req, dmem_we, dmem_addr, dmem_wdata, err_timeout);
    end
    tests++;
    if ({pc_wb_16, instr_wb_16, cw_wb_8, alu_wb_16, ld_wb_16, dest_wb_3} !== 83'd0) begin
      fails++;
      $display("FAIL reset wb: got cw=%h alu=%h ld=%h want 0", cw_wb_8, alu_wb_16, ld_wb_16);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_alu_passthrough();
    run_instr("alu", 16'h0010, 16'h1111, 8'h04, 16'h1234, 16'h0000, 3'd3, 0, 1'b0, 1'b0);
    run_instr("alu_hi", 16'h0012, 16'h2222, 8'hF4, 16'hFFFF, 16'h5555, 3'd7, 0, 1'b0, 1'b0);
  endtask

  task automatic test_load_zero_wait();
    ref_mem[8'h40] = 16'hBEEF;
    mem[8'h40]     = 16'hBEEF;
    run_instr("load0", 16'h0014, 16'h3333, 8'h0D, 16'h0040, 16'h0000, 3'd2, 0, 1'b0, 1'b0);
  endtask

  task automatic test_store_wait2();
    run_instr("store2", 16'h0016, 16'h4444, 8'h02, 16'h0080, 16'hA5A5, 3'd1, 2, 1'b0, 1'b0);
    tests++;
    if (mem[8'h80] !== 16'hA5A5) begin
      fails++;
      $display("FAIL store2 memory: got %h want a5a5", mem[8'h80]);
    end
    run_instr("loadback", 16'h0018, 16'h4445, 8'h01, 16'h0080, 16'h0000, 3'd4, 1, 1'b0, 1'b0);
  endtask

  task automatic test_flush_on_ack();
    run_instr("flush_ack", 16'h001A, 16'h5555, 8'h0D, 16'h0040, 16'h0000, 3'd5, 1, 1'b0, 1'b1);
    run_instr("after_flush", 16'h001C, 16'h6666, 8'h0D, 16'h0040, 16'h0000, 3'd6, 0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_access();
    pc_mem_16 = 16'h0020; instr_mem_16 = 16'h7777; cw_mem_8 = 8'h01;
    in_mem_16 = 16'h0055; ra_mem_16 = 16'h1234; dest_mem_3 = 3'd1;
    dmem_ack = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #2;
    tests++;
    if ({dmem_req, dmem_addr} !== {1'b1, 16'h0055}) begin
      fails++;
      $display("FAIL rst_mid pre: got req=%b addr=%h want req=1 addr=0055", dmem_req, dmem_addr);
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if ({dmem_req, dmem_we, dmem_addr, dmem_wdata, err_timeout} !== 35'd0) begin
      fails++;
      $display("FAIL rst_mid port: got req=%b addr=%h wdata=%h want 0", dmem_req, dmem_addr, dmem_wdata);
    end
    tests++;
    if ({pc_wb_16, instr_wb_16, cw_wb_8, alu_wb_16, ld_wb_16, dest_wb_3} !== 83'd0) begin
      fails++;
      $display("FAIL rst_mid wb: got cw=%h alu=%h want 0", cw_wb_8, alu_wb_16);
    end
    cw_mem_8 = 8'h00;
    @(posedge clk);
    #1 rst_n = 1'b1;
    run_instr("post_rst", 16'h0022, 16'h8888, 8'h04, 16'h0999, 16'h0000, 3'd2, 0, 1'b0, 1'b0);
  endtask

  task automatic test_timeout();
    run_instr("timeout", 16'h0024, 16'h9999, 8'h0D, 16'h0060, 16'h0000, 3'd3, 0, 1'b1, 1'b0);
    run_instr("after_to", 16'h0026, 16'hAAAA, 8'h04, 16'h4321, 16'h0000, 3'd4, 0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_instr("b2b_st", 16'h0028, 16'hB000, 8'h02, 16'h0033, 16'hC0DE, 3'd0, 0, 1'b0, 1'b0);
    run_instr("b2b_ld", 16'h002A, 16'hB001, 8'h0D, 16'h0033, 16'h0000, 3'd5, 0, 1'b0, 1'b0);
    run_instr("b2b_both", 16'h002C, 16'hB002, 8'h03, 16'h0034, 16'h7E57, 3'd6, 0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    logic [7:0] cw;
    for (int i = 0; i < 80; i++) begin
      cw = 8'($urandom);
      run_instr("rand", 16'($urandom), 16'($urandom), cw, 16'($urandom), 16'($urandom),
                3'($urandom), int'($urandom_range(0, 2)), ($urandom_range(0, 9) == 0),
                ($urandom_range(0, 9) == 0));
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]     = 16'h0000;
      ref_mem[i] = 16'h0000;
    end
    test_reset();
    test_alu_passthrough();
    test_load_zero_wait();
    test_store_wait2();
    test_flush_on_ack();
    test_back_to_back();
    test_reset_mid_access();
    test_timeout();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
